button_mode_scheduler: RTL

- Sits after the button logic block and sequences a shared LED pattern engine among the button requesters.
- Captures press events from the button logic state vector as pending requests.
- Grants one requester at a time using round-robin order, then runs a timed LED pattern for that requester.
- Reports busy/done status to the top level.

---
 rtl/button_mode_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/button_mode_scheduler.sv
// button_mode_scheduler
//   Shares one timed LED pattern engine among N_BUTTON requesters. Rising
//   edges on i_req become pending requests. A round-robin arbiter grants one
//   pending requester at a time, and that requester's pattern then runs for
//   N_STEPS steps of PRESCALE cycles each.
//
//   Request/grant protocol: i_req is a level. Only its rising edge counts as
//   a request, which is latched in pending until granted. There is no
//   back-pressure. o_grant is one-hot while the run is active (LOAD/RUN) and
//   is zero otherwise. o_done pulses for exactly one cycle when a run ends.
//
//   Optional build macro BUTTON_MODE_SCHED_PREEMPT_EN: when defined, a pending
//   request from any other requester aborts the active run (o_done still
//   pulses), and the aborting request is then served by normal arbitration.
//
// Ports:
//   i_clock   system clock
//   i_reset   asynchronous reset, active-low
//   i_req     request levels from the button logic state output
//   i_enable  step enable; low freezes the running pattern
//   o_grant   one-hot grant of the requester being served
//   o_busy    high while in LOAD or RUN
//   o_led     LED pattern
//   o_done    one-cycle pulse at the end of a run
//   o_state   debug view of the FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
module button_mode_scheduler #(
  parameter int N_BUTTON = 4,
  parameter int N_LEDS   = 4,
  parameter int PRESCALE = 1000,
  parameter int N_STEPS  = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [N_BUTTON-1:0] i_req,
  input  logic                i_enable,
  output logic [N_BUTTON-1:0] o_grant,
  output logic                o_busy,
  output logic [N_LEDS-1:0]   o_led,
  output logic                o_done,
  output logic [1:0]          o_state
);

  localparam int PW = (N_BUTTON > 1) ? $clog2(N_BUTTON) : 1;
  localparam int SW = $clog2(N_STEPS + 1);
  localparam int CW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [N_BUTTON-1:0] pending, req_d, rise, clr, cur_oh;
  logic [PW-1:0]       rr_ptr, cur, sel, rr_next;
  logic                found;
  logic [CW-1:0]       prescaler;
  logic [SW-1:0]       step;
  logic                run_end, preempt, last_tick;

  assign rise = i_req & ~req_d;

  // Round-robin search: the first pending bit at or after rr_ptr, wrapping.
  // This looks only at the registered pending vector, so a press landing on
  // the same edge as a grant waits for the next IDLE cycle.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < N_BUTTON; i++) begin
      idx = (int'(rr_ptr) + i) % N_BUTTON;
      if (!found && pending[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
    rr_next = PW'((int'(sel) + 1) % N_BUTTON);
  end

  always_comb begin
    clr = '0;
    if (state == S_IDLE && found) clr[sel] = 1'b1;
  end

  always_comb begin
    cur_oh      = '0;
    cur_oh[cur] = 1'b1;
  end

`ifdef BUTTON_MODE_SCHED_PREEMPT_EN
  assign preempt = (state == S_RUN) && |(pending & ~cur_oh);
`else
  assign preempt = 1'b0;
`endif

  // The run ends on the edge after step has counted up to N_STEPS, so the
  // last pattern position stays visible for one cycle before DONE.
  assign run_end   = (state == S_RUN) && (step == SW'(N_STEPS));
  assign last_tick = (prescaler == CW'(PRESCALE - 1));

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (found) state_next = S_LOAD;
      S_LOAD: state_next = S_RUN;
      S_RUN:  if (run_end || preempt) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign o_busy  = (state == S_LOAD) || (state == S_RUN);
  assign o_done  = (state == S_DONE);
  assign o_grant = o_busy ? cur_oh : '0;
  assign o_state = state;

  // Request capture, arbitration bookkeeping and the pattern datapath
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      req_d     <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      cur       <= '0;
      prescaler <= '0;
      step      <= '0;
      o_led     <= '0;
    end else begin
      req_d <= i_req;
      // A rise wins over a grant-clear of the same bit: presses are never lost.
      pending <= (pending & ~clr) | rise;
      if (state == S_IDLE && found) begin
        cur    <= sel;
        rr_ptr <= rr_next;
      end
      case (state)
        S_LOAD: begin
          prescaler <= '0;
          step      <= '0;
          // Even requesters sweep up from the LSB, odd ones down from the MSB.
          o_led     <= cur[0] ? (N_LEDS'(1) << (N_LEDS - 1)) : N_LEDS'(1);
        end
        S_RUN: begin
          if (run_end || preempt) begin
            o_led <= '0;
          end else if (i_enable) begin
            if (last_tick) begin
              prescaler <= '0;
              step      <= step + SW'(1);
              o_led     <= cur[0] ? {o_led[0], o_led[N_LEDS-1:1]}
                                  : {o_led[N_LEDS-2:0], o_led[N_LEDS-1]};
            end else begin
              prescaler <= prescaler + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
